iomem_led_display: RTL and testbench



---
 rtl/iomem_led_display.sv | 152 +++++++++++++++
 tb/tb_iomem_led_display.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_led_display.sv
// Memory-mapped LED bank and multiplexed 7-segment driver with PWM dimming.
// Digit d of a 4-digit group lives in byte lane 3-d, so the leftmost digit is the top byte.
module iomem_led_display #(
   parameter logic [7:0]  ADDR_PAGE  = 8'h03,
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned LED_WIDTH  = 32,
   parameter int unsigned PWM_BITS   = 8,
   parameter int unsigned SCAN_DIV   = 15
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  iomem_valid,
   output logic                  iomem_ready,
   input  logic [3:0]            iomem_wstrb,
   input  logic [31:0]           iomem_addr,
   input  logic [31:0]           iomem_wdata,
   output logic [31:0]           iomem_rdata,
   output logic [LED_WIDTH-1:0]  leds,
   output logic [7:0]            seg_data,
   output logic [NUM_DIGITS-1:0] seg_sel,
   output logic                  frame_tick
);

   localparam logic [2:0] LastIdx = 3'(NUM_DIGITS - 1);

   logic                 sel, wr, scan_on;
   logic [7:0]           offs;
   logic [31:0]          wmask, rd_val;
   logic                 ready_q, ready_d, tick_q, tick_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [LED_WIDTH-1:0] led_q, led_d;
   logic [PWM_BITS-1:0]  led_duty_q, led_duty_d, seg_duty_q, seg_duty_d, pwm_q, pwm_d;
   logic [1:0]           ctrl_q, ctrl_d;
   logic [7:0]           dig_q [8];
   logic [7:0]           dig_d [8];
   logic [SCAN_DIV-1:0]  presc_q, presc_d;
   logic [2:0]           idx_q, idx_d;
   logic                 unused_addr;

   assign unused_addr = ^iomem_addr[23:8];
   assign offs        = iomem_addr[7:0];
   assign sel         = iomem_valid && !ready_q && (iomem_addr[31:24] == ADDR_PAGE);
   assign wr          = sel && (iomem_wstrb != 4'b0000);

   always_comb begin
      for (int b = 0; b < 4; b++) wmask[8*b +: 8] = {8{iomem_wstrb[b]}};
   end

   always_comb begin
      rd_val = '0;
      case (offs)
         8'h00: rd_val = 32'(led_q);
         8'h04: rd_val = 32'(led_duty_q);
         8'h08: rd_val = 32'(seg_duty_q);
         8'h0C: rd_val = {30'd0, ctrl_q};
         8'h10: rd_val = {29'd0, idx_q};
         8'h20: begin
            for (int d = 0; d < 4; d++) rd_val[31-8*d -: 8] = dig_q[d];
         end
         8'h24: begin
            for (int d = 0; d < 4; d++) rd_val[31-8*d -: 8] = dig_q[d+4];
         end
         default: rd_val = '0;
      endcase
   end

   always_comb begin
      led_d      = led_q;
      led_duty_d = led_duty_q;
      seg_duty_d = seg_duty_q;
      ctrl_d     = ctrl_q;
      dig_d      = dig_q;
      if (wr) begin
         case (offs)
            8'h00: led_d = (led_q & ~wmask[LED_WIDTH-1:0])
                           | (iomem_wdata[LED_WIDTH-1:0] & wmask[LED_WIDTH-1:0]);
            8'h04: if (iomem_wstrb[0]) led_duty_d = iomem_wdata[PWM_BITS-1:0];
            8'h08: if (iomem_wstrb[0]) seg_duty_d = iomem_wdata[PWM_BITS-1:0];
            8'h0C: if (iomem_wstrb[0]) ctrl_d = iomem_wdata[1:0];
            8'h20: begin
               for (int d = 0; d < 4; d++) begin
                  if (iomem_wstrb[3-d] && (d < int'(NUM_DIGITS)))
                     dig_d[d] = iomem_wdata[31-8*d -: 8];
               end
            end
            8'h24: begin
               for (int d = 0; d < 4; d++) begin
                  if (iomem_wstrb[3-d] && ((d + 4) < int'(NUM_DIGITS)))
                     dig_d[d+4] = iomem_wdata[31-8*d -: 8];
               end
            end
            default: ;
         endcase
      end
   end

   // Free-running counters; the digit index steps when the prescaler wraps to zero.
   always_comb begin
      pwm_d   = pwm_q + PWM_BITS'(1);
      presc_d = presc_q + SCAN_DIV'(1);
      idx_d   = idx_q;
      tick_d  = 1'b0;
      if (&presc_q) begin
         tick_d = (idx_q == LastIdx);
         idx_d  = tick_d ? 3'd0 : idx_q + 3'd1;
      end
      ready_d = sel;
      rdata_d = sel ? rd_val : '0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready_q    <= 1'b0;
         rdata_q    <= '0;
         led_q      <= '0;
         led_duty_q <= '1;
         seg_duty_q <= '1;
         ctrl_q     <= 2'b01;
         for (int i = 0; i < 8; i++) dig_q[i] <= '0;
         pwm_q      <= '0;
         presc_q    <= '0;
         idx_q      <= '0;
         tick_q     <= 1'b0;
      end else begin
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
         led_q      <= led_d;
         led_duty_q <= led_duty_d;
         seg_duty_q <= seg_duty_d;
         ctrl_q     <= ctrl_d;
         dig_q      <= dig_d;
         pwm_q      <= pwm_d;
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         tick_q     <= tick_d;
      end
   end

   // Prescaler value zero is the dead-time cycle after each digit change.
   always_comb begin
      scan_on = ctrl_q[0] && !ctrl_q[1];
      leds    = (scan_on && (pwm_q < led_duty_q)) ? led_q : '0;
      seg_sel = (scan_on && (pwm_q < seg_duty_q) && (presc_q != '0))
                ? ~(NUM_DIGITS'(1) << idx_q) : '1;
   end

   assign seg_data    = dig_q[idx_q];
   assign frame_tick  = tick_q;
   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;

endmodule

// File: tb/tb_iomem_led_display.sv
// Directed bench for iomem_led_display; outputs compared each cycle to a cycle-count model.
module tb_iomem_led_display;

   logic        clk = 1'b0;
   logic        resetn;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic [31:0] leds;
   logic [7:0]  seg_data;
   logic [3:0]  seg_sel;
   logic        frame_tick;

   iomem_led_display #(
      .ADDR_PAGE (8'h03),
      .NUM_DIGITS(4),
      .LED_WIDTH (32),
      .PWM_BITS  (8),
      .SCAN_DIV  (4)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .iomem_valid(iomem_valid),
      .iomem_ready(iomem_ready),
      .iomem_wstrb(iomem_wstrb),
      .iomem_addr (iomem_addr),
      .iomem_wdata(iomem_wdata),
      .iomem_rdata(iomem_rdata),
      .leds       (leds),
      .seg_data   (seg_data),
      .seg_sel    (seg_sel),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   // Edges since reset release: pwm = n mod 256, prescaler = n mod 16, digit = (n/16) mod 4.
   int unsigned n;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) n <= 0;
      else         n <= n + 1;
   end

   logic [31:0] m_led;
   logic [7:0]  m_lduty, m_sduty;
   logic [1:0]  m_ctrl;
   logic [7:0]  m_dig [4];
   logic [7:0]  seg_codes [4] = '{8'h3F, 8'h06, 8'h5B, 8'h4F};
   logic [3:0]  sel_codes [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   int  n_chk, n_pass;
   bit  chk_on;
   logic prev_ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, want, $time);
   endtask

   function automatic int unsigned m_idx();
      return (n / 16) % 4;
   endfunction

   function automatic logic [31:0] m_leds();
      if (m_ctrl == 2'b01 && (n % 256) < m_lduty) return m_led;
      return 32'd0;
   endfunction

   function automatic logic [3:0] m_sel();
      if (m_ctrl == 2'b01 && (n % 256) < m_sduty && (n % 16) != 0)
         return ~(4'b0001 << m_idx());
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] o);
      case (o)
         8'h00:   return m_led;
         8'h04:   return {24'd0, m_lduty};
         8'h08:   return {24'd0, m_sduty};
         8'h0C:   return {30'd0, m_ctrl};
         8'h10:   return 32'(m_idx());
         8'h20:   return {m_dig[0], m_dig[1], m_dig[2], m_dig[3]};
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_write(input logic [7:0] o, input logic [3:0] s, input logic [31:0] wd);
      case (o)
         8'h00: for (int b = 0; b < 4; b++) if (s[b]) m_led[8*b +: 8] = wd[8*b +: 8];
         8'h04: if (s[0]) m_lduty = wd[7:0];
         8'h08: if (s[0]) m_sduty = wd[7:0];
         8'h0C: if (s[0]) m_ctrl = wd[1:0];
         8'h20: for (int d = 0; d < 4; d++) if (s[3-d]) m_dig[d] = wd[31-8*d -: 8];
         default: ;
      endcase
   endtask

   task automatic m_reset();
      m_led = 0; m_lduty = 8'hFF; m_sduty = 8'hFF; m_ctrl = 2'b01;
      for (int d = 0; d < 4; d++) m_dig[d] = 8'h00;
   endtask

   always @(negedge clk) begin
      if (resetn && chk_on) begin
         check("leds", leds, m_leds());
         check("seg_data", {24'd0, seg_data}, {24'd0, m_dig[m_idx()]});
         check("seg_sel", {28'd0, seg_sel}, {28'd0, m_sel()});
         check("frame_tick", {31'd0, frame_tick}, {31'd0, (n != 0 && n % 64 == 0)});
         check("ready_twice", {31'd0, iomem_ready && prev_ready}, 32'd0);
      end
      prev_ready = iomem_ready;
   end

   task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                      output logic [31:0] rd);
      logic [31:0] want;
      @(negedge clk);
      want        = m_read(addr[7:0]);
      iomem_valid = 1'b1;
      iomem_addr  = addr;
      iomem_wstrb = strb;
      iomem_wdata = wd;
      @(posedge clk); #1;
      check("ready_rise", {31'd0, iomem_ready}, 32'd1);
      check("rdata", iomem_rdata, want);
      if (strb != 4'b0000) m_write(addr[7:0], strb, wd);
      rd          = iomem_rdata;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'b0000;
      @(posedge clk); #1;
      check("ready_drop", {31'd0, iomem_ready}, 32'd0);
   endtask

   task automatic count_leds(input int cyc, output int cnt);
      cnt = 0;
      repeat (cyc) begin
         @(negedge clk);
         if (leds != 0) cnt++;
      end
   endtask

   task automatic wait_tick();
      bit found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (frame_tick) begin
            found = 1'b1;
            break;
         end
      end
      check("tick_found", {31'd0, found}, 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, s1, s2;
      int cnt, cnt2;
      n_chk = 0; n_pass = 0; chk_on = 1'b0;
      resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 0; iomem_addr = 0; iomem_wdata = 0;
      m_reset();
      repeat (2) @(negedge clk);
      check("rst_ready", {31'd0, iomem_ready}, 32'd0);
      check("rst_rdata", iomem_rdata, 32'd0);
      check("rst_leds", leds, 32'd0);
      check("rst_seg_sel", {28'd0, seg_sel}, 32'hF);
      check("rst_seg_data", {24'd0, seg_data}, 32'd0);
      check("rst_tick", {31'd0, frame_tick}, 32'd0);
      resetn = 1'b1;
      chk_on = 1'b1;

      bus(32'h0300_0004, 4'b0000, 0, rd); check("lit_led_duty_rst", rd, 32'hFF);
      bus(32'h0300_0008, 4'b0000, 0, rd); check("lit_seg_duty_rst", rd, 32'hFF);
      bus(32'h0300_000C, 4'b0000, 0, rd); check("lit_ctrl_rst", rd, 32'h1);

      bus(32'h0300_0000, 4'b0001, 32'h0000_00A5, rd);
      bus(32'h0300_0000, 4'b0000, 0, rd); check("lit_led_a5", rd, 32'h0000_00A5);
      count_leds(256, cnt); check("lit_on_255", cnt, 255);

      bus(32'h0300_0000, 4'b0100, 32'h1234_5678, rd);
      bus(32'h0300_0000, 4'b0000, 0, rd); check("lit_lane2", rd, 32'h0034_00A5);

      bus(32'h0300_0004, 4'b1111, 32'hFFFF_FF40, rd);
      bus(32'h0300_0004, 4'b0000, 0, rd); check("lit_duty40", rd, 32'h40);
      count_leds(256, cnt); check("lit_on_64", cnt, 64);
      bus(32'h0300_0004, 4'b0001, 32'h0, rd);
      count_leds(256, cnt); check("lit_on_0", cnt, 0);
      bus(32'h0300_0004, 4'b0001, 32'hFF, rd);

      bus(32'h0300_0020, 4'b1111, 32'h3F06_5B4F, rd);
      bus(32'h0300_0020, 4'b0000, 0, rd); check("lit_digits", rd, 32'h3F06_5B4F);
      wait_tick();
      for (int d = 0; d < 4; d++) begin
         check("lit_seg_data", {24'd0, seg_data}, {24'd0, seg_codes[d]});
         check("lit_dead", {28'd0, seg_sel}, 32'hF);
         @(negedge clk);
         check("lit_seg_sel", {28'd0, seg_sel}, {28'd0, sel_codes[d]});
         repeat (15) @(negedge clk);
      end
      check("lit_tick64", {31'd0, frame_tick}, 32'd1);

      bus(32'h0300_000C, 4'b0001, 32'h3, rd);
      cnt = 0; cnt2 = 0;
      repeat (64) begin
         @(negedge clk);
         if (leds != 0) cnt++;
         if (seg_sel != 4'hF) cnt2++;
      end
      check("lit_blank_leds", cnt, 0);
      check("lit_blank_sel", cnt2, 0);
      bus(32'h0300_0010, 4'b0000, 0, s1);
      repeat (14) @(posedge clk);
      bus(32'h0300_0010, 4'b0000, 0, s2);
      check("lit_status_adv", s2, (s1 + 1) % 4);
      bus(32'h0300_000C, 4'b0001, 32'h1, rd);

      @(negedge clk);
      iomem_valid = 1'b1; iomem_addr = 32'h0500_0000; iomem_wstrb = 4'hF; iomem_wdata = '1;
      cnt = 0;
      repeat (16) begin
         @(negedge clk);
         if (iomem_ready) cnt++;
      end
      check("lit_other_page", cnt, 0);
      iomem_valid = 1'b0; iomem_wstrb = 0;
      bus(32'h0300_0040, 4'b0000, 0, rd); check("lit_unmapped", rd, 32'd0);
      bus(32'h0300_0040, 4'b1111, 32'hFFFF_FFFF, rd);
      bus(32'h0300_0024, 4'b1111, 32'hFFFF_FFFF, rd);
      bus(32'h0300_0024, 4'b0000, 0, rd); check("lit_hi_digits", rd, 32'd0);
      bus(32'h0300_0020, 4'b0000, 0, rd); check("lit_digits_kept", rd, 32'h3F06_5B4F);

      // Reset while ready is high.
      @(negedge clk);
      iomem_valid = 1'b1; iomem_addr = 32'h0300_000C; iomem_wstrb = 0;
      @(posedge clk); #1;
      check("pre_rst_ready", {31'd0, iomem_ready}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      check("rst_ready_now", {31'd0, iomem_ready}, 32'd0);
      check("rst_rdata_now", iomem_rdata, 32'd0);
      iomem_valid = 1'b0;
      m_reset();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      bus(32'h0300_0000, 4'b0001, 32'hA5, rd);

      // Reset with a write pending, before the acknowledging edge.
      @(negedge clk);
      iomem_valid = 1'b1; iomem_addr = 32'h0300_0000; iomem_wstrb = 4'hF; iomem_wdata = '1;
      #2 resetn = 1'b0;
      #1;
      check("rst2_ready", {31'd0, iomem_ready}, 32'd0);
      check("rst2_leds", leds, 32'd0);
      m_reset();
      repeat (2) @(negedge clk);
      iomem_valid = 1'b0; iomem_wstrb = 0;
      @(negedge clk);
      resetn = 1'b1;
      bus(32'h0300_0000, 4'b0000, 0, rd); check("lit_no_stray", rd, 32'd0);
      bus(32'h0300_0004, 4'b0000, 0, rd); check("lit_duty_rst2", rd, 32'hFF);
      bus(32'h0300_000C, 4'b0000, 0, rd); check("lit_ctrl_rst2", rd, 32'h1);
      bus(32'h0300_0020, 4'b0000, 0, rd); check("lit_dig_rst2", rd, 32'd0);
      wait_tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
